mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Clocked FSM that sequences one SPARC V8 load/store/swap through the MAR, MDR, RAM, temp register and register-file write port, using the MFC handshake instead of fixed delays.
- The control unit issues `start` with the instruction's op3, rd and the low address bits from ALU_out. It waits for `done` (success) or `trap` (fault).
- Handles double-word (ldd/std) as two word accesses and performs alignment and illegal-operand checks.

Parameters:
- MFC_TIMEOUT, 16, maximum cycles spent in a wait state before raising a data-access trap.
- CW, 5, timeout counter width; must satisfy 2^CW > MFC_TIMEOUT.

Ports:
- Clk  in  1  rising-edge clock
- RESET  in  1  reset
- start  in  1  request; sampled only in IDLE
- op3  in  6  IR[24:19]
- rd  in  5  IR[29:25]
- addr_lo  in  3  ALU_out[2:0] at start
- MFC  in  1  memory function complete
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle success pulse
- trap  out  1  one-cycle fault pulse
- tt  out  3  trap type; held until next start
- MAR_Enable  out  1  MAR load
- MDR_Enable  out  1  MDR load
- MDR_Mux_select  out  1  1 = RAM data, 0 = register data
- RAM_enable  out  1  RAM strobe
- RAM_OpCode  out  6  op3 presented to RAM
- temp_enable  out  1  swap temp register load
- reg_write  out  1  register-file write strobe
- reg_addr  out  5  write destination, or store-data source port
- wb_from_temp  out  1  write-back data is from temp rather than MDR
- addr_plus4  out  1  address mux selects base+4 (second half of a double)

Behaviour:
- Reset is asynchronous, active-high on RESET.
  - All outputs go to 0, the state goes to IDLE and the timeout counter clears.
  - A reset mid-operation aborts the access with no `done`/`trap` pulse. Registers already written stay written.
- Accepted op3 values:
  - Loads: 000000, 000001, 000010, 001001, 001010.
  - ldd: 000011.
  - Stores: 000100, 000101, 000110.
  - std: 000111.
  - swap: 001111.
  - Any other value → TRAP, tt=010.
- Checks, evaluated in IDLE on the cycle `start` is sampled:
  - Word/swap with addr_lo[1:0]≠0 → TRAP, tt=001.
  - Half-word with addr_lo[0]≠0 → TRAP, tt=001.
  - Double with addr_lo≠000 → TRAP, tt=001.
  - Double with odd rd → TRAP, tt=010.
  - If any check fails, no strobe is issued.
- On acceptance: op3 and rd are latched, RAM_OpCode is driven from the latched op3, and the half flag is cleared.
- States, one cycle each unless noted:
  - IDLE: waits for `start`.
  - MAR: MAR_Enable=1; addr_plus4 = half flag.
  - RREQ: RAM_enable=1, MDR_Mux_select=1.
  - RWAIT: RAM_enable=1, MDR_Mux_select=1; held until MFC=1.
  - MDR: MDR_Enable=1, MDR_Mux_select=1.
  - WB: reg_write=1, reg_addr = rd | half.
  - SDATA: reg_addr = rd | half, MDR_Mux_select=0, MDR_Enable=1.
  - WREQ: RAM_enable=1.
  - WWAIT: RAM_enable=1; held until MFC=1.
  - TMP: temp_enable=1.
  - DONE: done=1.
  - TRAP: trap=1.
- Paths:
  - Load: MAR→RREQ→RWAIT→MDR→WB→DONE.
  - Store: MAR→SDATA→WREQ→WWAIT→DONE.
  - ldd: after the first WB, set half=1 and return to MAR. The second WB writes rd|1.
  - std: after the first WWAIT completes, set half=1 and return to MAR.
  - swap: MAR→RREQ→RWAIT→MDR→TMP→SDATA→WREQ→WWAIT→WB with wb_from_temp=1 →DONE.
- Timeout:
  - The counter clears on entering RWAIT/WWAIT and increments each cycle MFC=0.
  - When the counter reaches MFC_TIMEOUT → TRAP, tt=011, and RAM_enable deasserts.
  - A first ldd register already written remains written.
- Latency: load with MFC=1 on the first RWAIT cycle gives `done` 6 cycles after the start edge.
- Handshake and pulse rules:
  - `start` while busy is ignored.
  - `done` and `trap` are never both high.
  - After DONE or TRAP, return to IDLE; the next start can be accepted the following cycle.

Test Plan:
1. ld: op3=000000, rd=3, addr_lo=000, MFC high at RWAIT → strobes in order MAR, RAM, MDR, reg_write(reg_addr=3); done at cycle 6; tt unchanged.
2. ldd: op3=000011, rd=4, MFC 2 cycles late each half → reg_write to 4 then 5; addr_plus4=1 during the second MAR; single done pulse.
3. std with rd=5 → trap, tt=010, no MAR_Enable. sth with addr_lo=001 → trap, tt=001.
4. swap: op3=001111, rd=7 → temp_enable before the store MDR_Enable; final reg_write with wb_from_temp=1, reg_addr=7.
5. ld with MFC held low → trap after exactly 16 RWAIT cycles, tt=011, RAM_enable low on the trap cycle.
6. RESET asserted during RWAIT → all outputs 0 immediately; no done/trap; next start accepted normally. start pulsed while busy → ignored.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: sequences one SPARC V8 load / store / swap (including
// the ldd/std double-word forms) through MAR, MDR, RAM, the swap temp register
// and the register-file write port, using the MFC handshake for memory waits.
// All outputs are registered: each output flop is loaded from the value that
// belongs to the state being entered, so outputs change on the same edge as
// the state register.

module mem_access_sequencer #(
  parameter int MFC_TIMEOUT = 16,
  parameter int CW          = 5
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       start,
  input  logic [5:0] op3,
  input  logic [4:0] rd,
  input  logic [2:0] addr_lo,
  input  logic       MFC,
  output logic       busy,
  output logic       done,
  output logic       trap,
  output logic [2:0] tt,
  output logic       MAR_Enable,
  output logic       MDR_Enable,
  output logic       MDR_Mux_select,
  output logic       RAM_enable,
  output logic [5:0] RAM_OpCode,
  output logic       temp_enable,
  output logic       reg_write,
  output logic [4:0] reg_addr,
  output logic       wb_from_temp,
  output logic       addr_plus4
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_MAR   = 4'd1,
    S_RREQ  = 4'd2,
    S_RWAIT = 4'd3,
    S_MDR   = 4'd4,
    S_WB    = 4'd5,
    S_SDATA = 4'd6,
    S_WREQ  = 4'd7,
    S_WWAIT = 4'd8,
    S_TMP   = 4'd9,
    S_DONE  = 4'd10,
    S_TRAP  = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    K_ILL   = 3'd0,
    K_LOAD  = 3'd1,
    K_LDD   = 3'd2,
    K_STORE = 3'd3,
    K_STD   = 3'd4,
    K_SWAP  = 3'd5
  } kind_t;

  localparam logic [2:0] TT_ALIGN   = 3'b001;
  localparam logic [2:0] TT_ILLEGAL = 3'b010;
  localparam logic [2:0] TT_TIMEOUT = 3'b011;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(MFC_TIMEOUT);

  // Classify an op3 value into the access kind the sequencer understands.
  function automatic kind_t op_kind(input logic [5:0] op);
    kind_t k;
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010: k = K_LOAD;
      6'b000011:                                             k = K_LDD;
      6'b000100, 6'b000101, 6'b000110:                       k = K_STORE;
      6'b000111:                                             k = K_STD;
      6'b001111:                                             k = K_SWAP;
      default:                                               k = K_ILL;
    endcase
    return k;
  endfunction

  // Alignment rule per access size: word/swap on 4, half on 2, double on 8.
  function automatic logic misaligned(input logic [5:0] op, input logic [2:0] a);
    logic m;
    case (op)
      6'b000000, 6'b000100, 6'b001111: m = (a[1:0] != 2'b00);
      6'b000010, 6'b001010, 6'b000110: m = a[0];
      6'b000011, 6'b000111:            m = (a != 3'b000);
      default:                         m = 1'b0;
    endcase
    return m;
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    op3_q, op3_d;
  logic [4:0]    rd_q, rd_d;
  logic          half_q, half_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    tt_q, tt_d;
  kind_t         kind_in, kind_q, kind_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       trap_q, trap_d;
  logic       mar_en_q, mar_en_d;
  logic       mdr_en_q, mdr_en_d;
  logic       mdr_sel_q, mdr_sel_d;
  logic       ram_en_q, ram_en_d;
  logic       temp_en_q, temp_en_d;
  logic       reg_wr_q, reg_wr_d;
  logic [4:0] reg_addr_q, reg_addr_d;
  logic       wb_temp_q, wb_temp_d;
  logic       plus4_q, plus4_d;

  assign kind_in = op_kind(op3);
  assign kind_q  = op_kind(op3_q);
  assign kind_d  = op_kind(op3_d);
  assign cnt_inc = cnt_q + CW'(1);

  // Next-state logic: operand checks in IDLE, path selection and MFC timeout.
  always_comb begin
    state_d = state_q;
    op3_d   = op3_q;
    rd_d    = rd_q;
    half_d  = half_q;
    cnt_d   = '0;
    tt_d    = tt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (kind_in == K_ILL) begin
            state_d = S_TRAP;
            tt_d    = TT_ILLEGAL;
          end else if (misaligned(op3, addr_lo)) begin
            state_d = S_TRAP;
            tt_d    = TT_ALIGN;
          end else if ((kind_in == K_LDD || kind_in == K_STD) && rd[0]) begin
            state_d = S_TRAP;
            tt_d    = TT_ILLEGAL;
          end else begin
            state_d = S_MAR;
            op3_d   = op3;
            rd_d    = rd;
            half_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAR: begin
        if (kind_q == K_STORE || kind_q == K_STD) begin
          state_d = S_SDATA;
        end else begin
          state_d = S_RREQ;
        end
      end
      S_RREQ:  state_d = S_RWAIT;
      S_RWAIT: begin
        if (MFC) begin
          state_d = S_MDR;
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d = S_TRAP;
          tt_d    = TT_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MDR: begin
        if (kind_q == K_SWAP) begin
          state_d = S_TMP;
        end else begin
          state_d = S_WB;
        end
      end
      S_TMP:   state_d = S_SDATA;
      S_SDATA: state_d = S_WREQ;
      S_WREQ:  state_d = S_WWAIT;
      S_WWAIT: begin
        if (MFC) begin
          if (kind_q == K_SWAP) begin
            state_d = S_WB;
          end else if (kind_q == K_STD && !half_q) begin
            state_d = S_MAR;
            half_d  = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d = S_TRAP;
          tt_d    = TT_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB: begin
        if (kind_q == K_LDD && !half_q) begin
          state_d = S_MAR;
          half_d  = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_TRAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode for the state being entered, so the output flops track it.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = 1'b0;
    trap_d     = 1'b0;
    mar_en_d   = 1'b0;
    mdr_en_d   = 1'b0;
    mdr_sel_d  = 1'b0;
    ram_en_d   = 1'b0;
    temp_en_d  = 1'b0;
    reg_wr_d   = 1'b0;
    reg_addr_d = 5'd0;
    wb_temp_d  = 1'b0;
    plus4_d    = 1'b0;
    case (state_d)
      S_MAR: begin
        mar_en_d = 1'b1;
        plus4_d  = half_d;
      end
      S_RREQ, S_RWAIT: begin
        ram_en_d  = 1'b1;
        mdr_sel_d = 1'b1;
      end
      S_MDR: begin
        mdr_en_d  = 1'b1;
        mdr_sel_d = 1'b1;
      end
      S_WB: begin
        reg_wr_d   = 1'b1;
        reg_addr_d = rd_d | {4'b0000, half_d};
        wb_temp_d  = (kind_d == K_SWAP);
      end
      S_SDATA: begin
        reg_addr_d = rd_d | {4'b0000, half_d};
        mdr_en_d   = 1'b1;
      end
      S_WREQ, S_WWAIT: ram_en_d  = 1'b1;
      S_TMP:           temp_en_d = 1'b1;
      S_DONE:          done_d    = 1'b1;
      S_TRAP:          trap_d    = 1'b1;
      default:         busy_d    = (state_d != S_IDLE);
    endcase
  end

  // State, operand latches, timeout counter and registered outputs.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      op3_q      <= 6'd0;
      rd_q       <= 5'd0;
      half_q     <= 1'b0;
      cnt_q      <= '0;
      tt_q       <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      trap_q     <= 1'b0;
      mar_en_q   <= 1'b0;
      mdr_en_q   <= 1'b0;
      mdr_sel_q  <= 1'b0;
      ram_en_q   <= 1'b0;
      temp_en_q  <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= 5'd0;
      wb_temp_q  <= 1'b0;
      plus4_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op3_q      <= op3_d;
      rd_q       <= rd_d;
      half_q     <= half_d;
      cnt_q      <= cnt_d;
      tt_q       <= tt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      trap_q     <= trap_d;
      mar_en_q   <= mar_en_d;
      mdr_en_q   <= mdr_en_d;
      mdr_sel_q  <= mdr_sel_d;
      ram_en_q   <= ram_en_d;
      temp_en_q  <= temp_en_d;
      reg_wr_q   <= reg_wr_d;
      reg_addr_q <= reg_addr_d;
      wb_temp_q  <= wb_temp_d;
      plus4_q    <= plus4_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign trap           = trap_q;
  assign tt             = tt_q;
  assign MAR_Enable     = mar_en_q;
  assign MDR_Enable     = mdr_en_q;
  assign MDR_Mux_select = mdr_sel_q;
  assign RAM_enable     = ram_en_q;
  assign RAM_OpCode     = op3_q;
  assign temp_enable    = temp_en_q;
  assign reg_write      = reg_wr_q;
  assign reg_addr       = reg_addr_q;
  assign wb_from_temp   = wb_temp_q;
  assign addr_plus4     = plus4_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: a table of hand-computed transactions, a
// reset-abort sequence, then randomized transactions checked against a
// transaction-level model (strobe order, outcome, latency, trap type).

module tb_mem_access_sequencer;

  localparam int TMO = 16;

  logic       Clk = 1'b0;
  logic       RESET;
  logic       start;
  logic [5:0] op3;
  logic [4:0] rd;
  logic [2:0] addr_lo;
  logic       MFC;
  logic       busy, done, trap;
  logic [2:0] tt;
  logic       MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable;
  logic [5:0] RAM_OpCode;
  logic       temp_enable, reg_write;
  logic [4:0] reg_addr;
  logic       wb_from_temp, addr_plus4;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mem_access_sequencer #(.MFC_TIMEOUT(TMO), .CW(5)) dut (
    .Clk(Clk), .RESET(RESET), .start(start), .op3(op3), .rd(rd),
    .addr_lo(addr_lo), .MFC(MFC), .busy(busy), .done(done), .trap(trap),
    .tt(tt), .MAR_Enable(MAR_Enable), .MDR_Enable(MDR_Enable),
    .MDR_Mux_select(MDR_Mux_select), .RAM_enable(RAM_enable),
    .RAM_OpCode(RAM_OpCode), .temp_enable(temp_enable),
    .reg_write(reg_write), .reg_addr(reg_addr),
    .wb_from_temp(wb_from_temp), .addr_plus4(addr_plus4)
  );

  typedef struct {
    logic [5:0] op;
    logic [4:0] rd;
    logic [2:0] a;
    int         d;
    logic       is_trap;
    logic [2:0] tt;
    int         cyc;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  logic [2:0] last_tt;
  int         ram_run;
  int         mfc_d;

  // Event kinds recorded from strobes: {kind, flag, reg}.
  localparam int EV_MAR = 1, EV_MDR = 2, EV_SD = 3, EV_TMP = 4, EV_WB = 5;

  function automatic logic [9:0] ev(input int kind, input logic f, input logic [4:0] r);
    return {4'(kind), f, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Transaction-level reference: outcome, latency and strobe order.
  task automatic model(input logic [5:0] op, input logic [4:0] r, input logic [2:0] a,
                       input int d, output logic trp, output logic [2:0] t, output int cyc);
    int  kind;
    int  ai;
    int  ri;
    bit  mis;
    bit  ldfam;
    ai = int'(a);
    ri = int'(r);
    exp_q.delete();
    case (op)
      6'b000000, 6'b000001, 6'b001001: begin kind = 1; mis = 1'b0; end
      6'b000010, 6'b001010:            begin kind = 1; mis = (ai % 2) != 0; end
      6'b000011:                       begin kind = 2; mis = ai != 0; end
      6'b000100, 6'b000101:            begin kind = 3; mis = 1'b0; end
      6'b000110:                       begin kind = 3; mis = (ai % 2) != 0; end
      6'b000111:                       begin kind = 4; mis = ai != 0; end
      6'b001111:                       begin kind = 5; mis = 1'b0; end
      default:                         begin kind = 0; mis = 1'b0; end
    endcase
    if (op == 6'b000000 || op == 6'b000100) mis = (ai % 4) != 0;
    if (op == 6'b001111) mis = (ai % 4) != 0;
    trp = 1'b1;
    cyc = 1;
    if (kind == 0) begin t = 3'b010; return; end
    if (mis) begin t = 3'b001; return; end
    if ((kind == 2 || kind == 4) && (ri % 2) == 1) begin t = 3'b010; return; end
    ldfam = (kind == 1 || kind == 2 || kind == 5);
    exp_q.push_back(ev(EV_MAR, 1'b0, 5'd0));
    if (d >= TMO) begin
      t = 3'b011;
      if (ldfam) cyc = 2 + TMO + 1;
      else begin
        exp_q.push_back(ev(EV_SD, 1'b0, r));
        cyc = 3 + TMO + 1;
      end
      return;
    end
    trp = 1'b0;
    t   = last_tt;
    case (kind)
      1: begin
        exp_q.push_back(ev(EV_MDR, 1'b0, 5'd0));
        exp_q.push_back(ev(EV_WB, 1'b0, r));
        cyc = 6 + d;
      end
      2: begin
        exp_q.push_back(ev(EV_MDR, 1'b0, 5'd0));
        exp_q.push_back(ev(EV_WB, 1'b0, r));
        exp_q.push_back(ev(EV_MAR, 1'b1, 5'd0));
        exp_q.push_back(ev(EV_MDR, 1'b0, 5'd0));
        exp_q.push_back(ev(EV_WB, 1'b0, r | 5'd1));
        cyc = 11 + 2 * d;
      end
      3: begin
        exp_q.push_back(ev(EV_SD, 1'b0, r));
        cyc = 5 + d;
      end
      4: begin
        exp_q.push_back(ev(EV_SD, 1'b0, r));
        exp_q.push_back(ev(EV_MAR, 1'b1, 5'd0));
        exp_q.push_back(ev(EV_SD, 1'b0, r | 5'd1));
        cyc = 9 + 2 * d;
      end
      default: begin
        exp_q.push_back(ev(EV_MDR, 1'b0, 5'd0));
        exp_q.push_back(ev(EV_TMP, 1'b0, 5'd0));
        exp_q.push_back(ev(EV_SD, 1'b0, r));
        exp_q.push_back(ev(EV_WB, 1'b1, r));
        cyc = 10 + 2 * d;
      end
    endcase
  endtask

  // Runs one transaction starting at a negedge; a memory responder raises MFC
  // d cycles after the first wait cycle. Optionally pokes start while busy.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [4:0] r,
                        input logic [2:0] a, input int d, input bit poke,
                        input logic exp_trap, input logic [2:0] exp_tt, input int exp_cyc);
    bit         seen;
    int         cyc_seen;
    logic       tr;
    logic [2:0] tt_seen;
    logic       ren;
    int         n;
    seen = 1'b0; cyc_seen = 0; tr = 1'b0; tt_seen = 3'd0; ren = 1'b0;
    op3 = op; rd = r; addr_lo = a; start = 1'b1;
    mfc_d = d; ram_run = 0; MFC = 1'b0;
    got_q.delete();
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge Clk);
      start = poke && (c == 2);
      if (poke && c == 2) begin
        op3 = 6'($urandom); rd = 5'($urandom); addr_lo = 3'($urandom);
      end
      if (MAR_Enable) begin
        got_q.push_back(ev(EV_MAR, addr_plus4, 5'd0));
        chk({tag, "_opcode"}, RAM_OpCode, op);
      end
      if (MDR_Enable && MDR_Mux_select) got_q.push_back(ev(EV_MDR, 1'b0, 5'd0));
      if (MDR_Enable && !MDR_Mux_select) got_q.push_back(ev(EV_SD, 1'b0, reg_addr));
      if (temp_enable) got_q.push_back(ev(EV_TMP, 1'b0, 5'd0));
      if (reg_write) got_q.push_back(ev(EV_WB, wb_from_temp, reg_addr));
      chk({tag, "_done_trap_excl"}, done & trap, 1'b0);
      ram_run = RAM_enable ? ram_run + 1 : 0;
      MFC = RAM_enable && (ram_run >= 2 + mfc_d);
      if (done || trap) begin
        seen = 1'b1; cyc_seen = c; tr = trap; tt_seen = tt; ren = RAM_enable;
      end
    end
    MFC = 1'b0;
    start = 1'b0;
    chk({tag, "_finished"}, seen, 1'b1);
    chk({tag, "_is_trap"}, tr, exp_trap);
    chk({tag, "_cycle"}, cyc_seen, exp_cyc);
    chk({tag, "_tt"}, tt_seen, exp_trap ? exp_tt : last_tt);
    if (tr) chk({tag, "_ram_off_at_trap"}, ren, 1'b0);
    chk({tag, "_event_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_event%0d", tag, i), got_q[i], exp_q[i]);
    if (exp_trap) last_tt = exp_tt;
    @(negedge Clk);
    chk({tag, "_idle_after"}, {busy, done, trap}, 3'b000);
  endtask

  function automatic logic [24:0] all_outs();
    return {busy, done, trap, tt, MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable,
            RAM_OpCode, temp_enable, reg_write, reg_addr, wb_from_temp, addr_plus4};
  endfunction

  initial begin
    logic [5:0] ops[11];
    logic [5:0] op;
    logic [4:0] r;
    logic [2:0] a;
    int         d;
    int         dl[7];
    logic       etrp;
    logic [2:0] ett;
    int         ecyc;

    ops = '{6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010, 6'b000011,
            6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b001111};
    dl  = '{0, 1, 2, 3, 15, 16, 40};

    //            op         rd     a     d    trap  tt      cyc
    vecs.push_back('{6'b000000, 5'd3, 3'd0, 0,   1'b0, 3'd0,   6});
    vecs.push_back('{6'b000011, 5'd4, 3'd0, 2,   1'b0, 3'd0,  15});
    vecs.push_back('{6'b000111, 5'd5, 3'd0, 0,   1'b1, 3'b010, 1});
    vecs.push_back('{6'b000110, 5'd3, 3'd1, 0,   1'b1, 3'b001, 1});
    vecs.push_back('{6'b001111, 5'd7, 3'd0, 0,   1'b0, 3'd0,  10});
    vecs.push_back('{6'b000100, 5'd2, 3'd0, 1,   1'b0, 3'd0,   6});
    vecs.push_back('{6'b000111, 5'd2, 3'd0, 0,   1'b0, 3'd0,   9});
    vecs.push_back('{6'b001010, 5'd1, 3'd2, 0,   1'b0, 3'd0,   6});
    vecs.push_back('{6'b001010, 5'd1, 3'd3, 0,   1'b1, 3'b001, 1});
    vecs.push_back('{6'b000001, 5'd9, 3'd7, 0,   1'b0, 3'd0,   6});
    vecs.push_back('{6'b111111, 5'd0, 3'd0, 0,   1'b1, 3'b010, 1});
    vecs.push_back('{6'b000011, 5'd4, 3'd4, 0,   1'b1, 3'b001, 1});
    vecs.push_back('{6'b001111, 5'd7, 3'd2, 0,   1'b1, 3'b001, 1});
    vecs.push_back('{6'b000000, 5'd1, 3'd0, 15,  1'b0, 3'd0,  21});
    vecs.push_back('{6'b000100, 5'd0, 3'd0, 100, 1'b1, 3'b011, 20});
    vecs.push_back('{6'b000000, 5'd1, 3'd0, 100, 1'b1, 3'b011, 19});

    RESET = 1'b1; start = 1'b0; MFC = 1'b0; op3 = 6'd0; rd = 5'd0; addr_lo = 3'd0;
    last_tt = 3'd0; ram_run = 0; mfc_d = 0;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", all_outs(), 25'd0);
    RESET = 1'b0;
    @(negedge Clk);
    chk("post_reset_idle", all_outs(), 25'd0);

    foreach (vecs[i]) begin
      model(vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].d, etrp, ett, ecyc);
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rd, vecs[i].a, vecs[i].d,
             !vecs[i].is_trap || vecs[i].cyc > 3,
             vecs[i].is_trap, vecs[i].tt, vecs[i].cyc);
    end

    // Reset in the middle of a read wait: outputs clear at once, no pulse follows.
    op3 = 6'b000000; rd = 5'd6; addr_lo = 3'd0; start = 1'b1; MFC = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      start = 1'b0;
    end
    chk("rst_mid_busy", busy, 1'b1);
    chk("rst_mid_ram", RAM_enable, 1'b1);
    #2 RESET = 1'b1;
    #1 chk("rst_async_clear", all_outs(), 25'd0);
    @(negedge Clk);
    RESET = 1'b0;
    last_tt = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk($sformatf("rst_quiet%0d", c), {busy, done, trap}, 3'b000);
    end
    model(6'b000000, 5'd6, 3'd0, 0, etrp, ett, ecyc);
    run_op("after_reset_ld", 6'b000000, 5'd6, 3'd0, 0, 1'b1, etrp, ett, ecyc);

    for (int k = 0; k < 40; k++) begin
      int idx;
      idx = $urandom_range(0, 11);
      op  = (idx == 11) ? 6'($urandom) : ops[idx];
      r   = 5'($urandom);
      a   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
      d   = dl[$urandom_range(0, 6)];
      model(op, r, a, d, etrp, ett, ecyc);
      run_op($sformatf("rnd%0d", k), op, r, a, d, ecyc > 3, etrp, ett, ecyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
